// File: rtl/regfile_pkg.sv
// Shared register-file constants and types for the mini-MIPS 8x32 register file.
// Used by the write-port arbiter, the register file and decode.
package regfile_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0]   reg_addr_t;
    typedef logic [DATA_W-1:0]   reg_data_t;
    typedef logic [NUM_REGS-1:0] reg_mask_t;

    localparam reg_addr_t ZERO_REG = '0;

    function automatic reg_mask_t addr_onehot(input reg_addr_t addr);
        return reg_mask_t'(1) << addr;
    endfunction
endpackage

// File: rtl/regwrite_arbiter_if.sv
// Writeback request bundle: two requesters (ALU, load) plus the issue-stage reservation.
interface regwrite_arbiter_if;
    import regfile_pkg::*;

    logic      req0_valid;
    reg_addr_t req0_addr;
    reg_data_t req0_data;
    logic      req0_ready;

    logic      req1_valid;
    reg_addr_t req1_addr;
    reg_data_t req1_data;
    logic      req1_ready;

    logic      rsv_valid;
    reg_addr_t rsv_addr;

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  rsv_valid, rsv_addr,
        output req0_ready, req1_ready
    );

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output rsv_valid, rsv_addr,
        input  req0_ready, req1_ready
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant logic; prio names the requester preferred on a conflict
// and flips to the loser after every transfer.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    output logic [1:0] ready,
    output logic       grant_idx,
    output logic       fire
);
    logic prio;

    always_comb begin
        ready     = 2'b00;
        grant_idx = 1'b0;
        if (!reset) begin
            if (valid[0] && valid[1]) begin
                grant_idx = prio;
            end else begin
                grant_idx = valid[1];
            end
            if (|valid) begin
                ready = grant_idx ? 2'b10 : 2'b01;
            end
        end
    end

    assign fire = |ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio <= 1'b0;
        end else if (fire) begin
            prio <= ~grant_idx;
        end
    end
endmodule

// File: rtl/regwrite_arbiter.sv
// Register-file write-port arbiter: round-robin between ALU and load writeback,
// registered write stage with register-0 filter, and per-register busy scoreboard.
module regwrite_arbiter
    import regfile_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    regwrite_arbiter_if.slave          bus,
    output logic                       RegWrite,
    output reg_addr_t                  WriteRegister,
    output reg_data_t                  WriteData,
    output reg_mask_t                  busy_mask,
    output logic                       grant_last
);
    logic [1:0] ready;
    logic       grant_idx;
    logic       fire;
    reg_addr_t  sel_addr;
    reg_data_t  sel_data;
    logic       real_write;
    reg_mask_t  busy_next;

    rr_arbiter2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .valid     ({bus.req1_valid, bus.req0_valid}),
        .ready     (ready),
        .grant_idx (grant_idx),
        .fire      (fire)
    );

    assign bus.req0_ready = ready[0];
    assign bus.req1_ready = ready[1];

    assign sel_addr   = grant_idx ? bus.req1_addr : bus.req0_addr;
    assign sel_data   = grant_idx ? bus.req1_data : bus.req0_data;
    assign real_write = fire && (sel_addr != ZERO_REG);

    // A reservation landing on the committing register wins, so set after clear.
    always_comb begin
        busy_next = busy_mask;
        if (fire) begin
            busy_next = busy_next & ~addr_onehot(sel_addr);
        end
        if (bus.rsv_valid && (bus.rsv_addr != ZERO_REG)) begin
            busy_next = busy_next | addr_onehot(bus.rsv_addr);
        end
        busy_next[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
            busy_mask     <= '0;
            grant_last    <= 1'b0;
        end else begin
            RegWrite  <= real_write;
            busy_mask <= busy_next;
            if (real_write) begin
                WriteRegister <= sel_addr;
                WriteData     <= sel_data;
            end
            if (fire) begin
                grant_last <= grant_idx;
            end
        end
    end
endmodule

// File: tb/tb_regwrite_arbiter.sv
// Bench for regwrite_arbiter: directed scenarios plus a randomized stream, all checked
// against a transaction-level model of the arbitration and scoreboard rules.
module tb_regwrite_arbiter;
    import regfile_pkg::*;

    logic      clk = 1'b0;
    logic      reset;
    logic      RegWrite;
    reg_addr_t WriteRegister;
    reg_data_t WriteData;
    reg_mask_t busy_mask;
    logic      grant_last;

    int errors = 0;
    int checks = 0;

    // model state
    bit        m_prio;
    bit        m_gl;
    bit        m_rw;
    logic [2:0]  m_wr;
    logic [31:0] m_wd;
    logic [7:0]  m_busy;

    regwrite_arbiter_if bus ();

    regwrite_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .busy_mask     (busy_mask),
        .grant_last    (grant_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prio = 0; m_gl = 0; m_rw = 0; m_wr = '0; m_wd = '0; m_busy = '0;
    endtask

    task automatic check_outputs();
        chk("RegWrite", RegWrite, m_rw);
        chk("busy_mask", busy_mask, m_busy);
        chk("grant_last", grant_last, m_gl);
        if (m_rw) begin
            chk("WriteRegister", WriteRegister, m_wr);
            chk("WriteData", WriteData, m_wd);
        end
    endtask

    // One clock: drive requests, check readies mid-cycle, advance model at the edge.
    task automatic cycle(input bit v0, input logic [2:0] a0, input logic [31:0] d0,
                         input bit v1, input logic [2:0] a1, input logic [31:0] d1,
                         input bit rv, input logic [2:0] ra,
                         output bit fired, output bit gidx);
        logic [2:0]  a;
        logic [31:0] d;
        bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
        bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
        bus.rsv_valid  = rv; bus.rsv_addr  = ra;
        fired = v0 || v1;
        gidx  = (v0 && v1) ? m_prio : v1;
        @(negedge clk);
        chk("req0_ready", bus.req0_ready, fired && !gidx);
        chk("req1_ready", bus.req1_ready, fired && gidx);
        @(posedge clk);
        #1;
        if (fired) begin
            a = gidx ? a1 : a0;
            d = gidx ? d1 : d0;
            m_prio = !gidx;
            m_gl   = gidx;
            m_rw   = (a != 3'd0);
            if (a != 3'd0) begin
                m_wr = a;
                m_wd = d;
            end
            m_busy[a] = 1'b0;
        end else begin
            m_rw = 0;
        end
        if (rv && ra != 3'd0) m_busy[ra] = 1'b1;
        check_outputs();
    endtask

    task automatic idle();
        bit f, g;
        cycle(0, 0, 0, 0, 0, 0, 0, 0, f, g);
    endtask

    initial begin
        bit f, g;
        bit p0v, p1v;
        logic [2:0]  p0a, p1a;
        logic [31:0] p0d, p1d;
        int gseq;

        bus.req0_valid = 1; bus.req0_addr = 3'd1; bus.req0_data = 32'h1;
        bus.req1_valid = 1; bus.req1_addr = 3'd2; bus.req1_data = 32'h2;
        bus.rsv_valid = 0;  bus.rsv_addr = 0;
        reset = 1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_req0_ready", bus.req0_ready, 1'b0);
        chk("rst_req1_ready", bus.req1_ready, 1'b0);
        check_outputs();
        bus.req0_valid = 0; bus.req1_valid = 0;
        reset = 0;
        @(posedge clk);
        #1;

        // single write, then RegWrite drops
        cycle(1, 3'd2, 32'h5555_5555, 0, 0, 0, 0, 0, f, g);
        chk("first_wdata", WriteData, 32'h5555_5555);
        idle();
        chk("first_drop", RegWrite, 1'b0);

        // both valid: alternating grants starting from the pointer's current value
        gseq = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1, 3'd3, 32'h3000_0000 + i, 1, 3'd7, 32'h7000_0000 + i, 0, 0, f, g);
            gseq = (gseq << 1) | int'(g);
        end
        chk("alt_grants", gseq, 32'b1010);
        idle();

        // reserve 7, then commit 7 from the load path
        cycle(0, 0, 0, 0, 0, 0, 1, 3'd7, f, g);
        chk("rsv7_mask", busy_mask, 8'h80);
        cycle(0, 0, 0, 1, 3'd7, 32'h0000_FFFF, 0, 0, f, g);
        chk("commit7_mask", busy_mask, 8'h00);

        // reservation and commit to 5 in the same cycle
        cycle(0, 0, 0, 0, 0, 0, 1, 3'd5, f, g);
        cycle(1, 3'd5, 32'hABCD_0005, 0, 0, 0, 1, 3'd5, f, g);
        chk("rsv_wins_bit5", busy_mask[5], 1'b1);
        cycle(0, 0, 0, 1, 3'd5, 32'h0, 0, 0, f, g);

        // writes to register 0 are consumed but never reach the file
        cycle(1, 3'd0, 32'hFFFF_FFFF, 0, 0, 0, 1, 3'd0, f, g);
        chk("zero_no_write", RegWrite, 1'b0);
        chk("zero_mask", busy_mask, 8'h00);

        // reset while a write is pending and registers 2,3 are busy
        cycle(0, 0, 0, 0, 0, 0, 1, 3'd2, f, g);
        cycle(1, 3'd1, 32'h1111_1111, 0, 0, 0, 1, 3'd3, f, g);
        chk("pre_rst_rw", RegWrite, 1'b1);
        chk("pre_rst_mask", busy_mask, 8'h0C);
        bus.req0_valid = 1; bus.req1_valid = 1;
        reset = 1;
        model_reset();
        #1;
        chk("async_rw", RegWrite, 1'b0);
        chk("async_mask", busy_mask, 8'h00);
        chk("async_ready0", bus.req0_ready, 1'b0);
        chk("async_ready1", bus.req1_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_edge_rw", RegWrite, 1'b0);
        bus.req0_valid = 0; bus.req1_valid = 0;
        reset = 0;
        cycle(1, 3'd4, 32'h4444, 1, 3'd6, 32'h6666, 0, 0, f, g);
        chk("prio_after_rst", g, 1'b0);

        // randomized stream: each source holds its request until granted
        p0v = 0; p1v = 0;
        p0a = 0; p1a = 0; p0d = 0; p1d = 0;
        for (int i = 0; i < 300; i++) begin
            if (!p0v && ($urandom % 3 != 0)) begin
                p0v = 1; p0a = 3'($urandom); p0d = $urandom;
            end
            if (!p1v && ($urandom % 3 != 0)) begin
                p1v = 1; p1a = 3'($urandom); p1d = $urandom;
            end
            cycle(p0v, p0a, p0d, p1v, p1a, p1d,
                  ($urandom % 3 == 0), 3'($urandom), f, g);
            if (f && !g) p0v = 0;
            if (f && g)  p1v = 0;
        end
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
